// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter in front of the UART TX
// write port. Each grant emits a {HDR_TAG, grant_id} header byte followed by
// the granted requester's payload, up to MAX_LEN bytes per grant.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned DATA_WIDTH = 8,
   parameter logic [3:0]  HDR_TAG    = 4'hA,
   parameter int unsigned MAX_LEN    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          uart_wr,
   output logic [DATA_WIDTH-1:0]         uart_din,
   input  logic                          uart_almost_full,
   output logic [3:0]                    grant_id,
   output logic                          busy,
   output logic                          err_overlen
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      grant_id_q, grant_id_d;
   logic [3:0]      last_ptr_q, last_ptr_d;
   logic [7:0]      byte_cnt_q, byte_cnt_d;
   logic            busy_q, busy_d;
   logic            err_overlen_q, err_overlen_d;

   logic            any_valid;
   logic [3:0]      rr_pick;
   logic [NUM_REQ-1:0]    gnt_onehot;
   logic            sel_valid;
   logic            sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic            at_limit;

   // Round-robin pick: rank each valid requester by its distance after last_ptr
   // and keep the nearest one.
   always_comb begin
      int unsigned lp;
      int unsigned rank;
      int unsigned best_rank;
      lp        = 32'(last_ptr_q);
      rank      = 0;
      best_rank = NUM_REQ;
      any_valid = 1'b0;
      rr_pick   = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (j > lp) begin
            rank = j - lp - 1;
         end else begin
            rank = j + NUM_REQ - lp - 1;
         end
         if (req_valid[j] && (rank < best_rank)) begin
            best_rank = rank;
            rr_pick   = 4'(j);
            any_valid = 1'b1;
         end
      end
   end

   // Mux out the granted requester's valid/last/data and its one-hot select.
   always_comb begin
      gnt_onehot = '0;
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      sel_data   = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (grant_id_q == 4'(j)) begin
            gnt_onehot[j] = 1'b1;
            sel_valid     = req_valid[j];
            sel_last      = req_last[j];
            sel_data      = req_data[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign at_limit = (byte_cnt_q == 8'(MAX_LEN - 1));

   // Next-state and write-port outputs for the IDLE/HDR/DATA sequence.
   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      last_ptr_d    = last_ptr_q;
      byte_cnt_d    = byte_cnt_q;
      err_overlen_d = 1'b0;
      uart_wr       = 1'b0;
      uart_din      = sel_data;
      req_ready     = '0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant_id_d = rr_pick;
               state_d    = HDR;
            end
         end
         HDR: begin
            uart_din = {HDR_TAG, grant_id_q};
            uart_wr  = !uart_almost_full;
            if (!uart_almost_full) begin
               state_d = DATA;
            end
         end
         DATA: begin
            req_ready = gnt_onehot & {NUM_REQ{!uart_almost_full}};
            uart_wr   = sel_valid && !uart_almost_full;
            if (uart_wr) begin
               if (sel_last || at_limit) begin
                  last_ptr_d    = grant_id_q;
                  byte_cnt_d    = '0;
                  state_d       = IDLE;
                  err_overlen_d = !sel_last;
               end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_id_q    <= '0;
         last_ptr_q    <= 4'(NUM_REQ - 1);
         byte_cnt_q    <= '0;
         busy_q        <= 1'b0;
         err_overlen_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         last_ptr_q    <= last_ptr_d;
         byte_cnt_q    <= byte_cnt_d;
         busy_q        <= busy_d;
         err_overlen_q <= err_overlen_d;
      end
   end

   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign err_overlen = err_overlen_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers feed byte queues,
// a packet-level reference model predicts the UART byte stream, and a
// monitor compares every UART write and every err_overlen sample.
module tb_uart_tx_arbiter;
   localparam int unsigned NREQ = 3;
   localparam int unsigned MAXL = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*8-1:0] req_data = '0;
   logic [NREQ-1:0]   req_last = '0;
   logic [NREQ-1:0]   req_ready;
   logic              uart_wr;
   logic [7:0]        uart_din;
   logic              uart_almost_full = 1'b0;
   logic [3:0]        grant_id;
   logic              busy;
   logic              err_overlen;

   uart_tx_arbiter #(
      .NUM_REQ   (NREQ),
      .DATA_WIDTH(8),
      .HDR_TAG   (4'hA),
      .MAX_LEN   (MAXL)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_last        (req_last),
      .req_ready       (req_ready),
      .uart_wr         (uart_wr),
      .uart_din        (uart_din),
      .uart_almost_full(uart_almost_full),
      .grant_id        (grant_id),
      .busy            (busy),
      .err_overlen     (err_overlen)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // {last, byte} per requester: drv_q feeds the pins, mq feeds the model
   logic [8:0]  drv_q [NREQ][$];
   logic [8:0]  mq    [NREQ][$];
   // {cut, byte} expected on the UART
   logic [8:0]  exp_q [$];
   int unsigned model_last = NREQ - 1;

   logic        mon_en = 1'b0;
   logic        err_exp = 1'b0;
   logic        busy_cnt_en = 1'b0;
   int unsigned busy_cnt = 0;
   int unsigned af_pct = 0;
   int unsigned af_burst = 0;
   logic [NREQ-1:0] acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_outputs();
      logic [8:0] it;
      for (int unsigned r = 0; r < NREQ; r++) begin
         if (drv_q[r].size() > 0) begin
            it = drv_q[r][0];
            req_valid[r]       = 1'b1;
            req_data[8*r +: 8] = it[7:0];
            req_last[r]        = it[8];
         end else begin
            req_valid[r] = 1'b0;
            req_last[r]  = 1'b0;
         end
      end
   endtask

   task automatic add_byte(input int unsigned r, input logic [7:0] b, input logic last);
      drv_q[r].push_back({last, b});
      mq[r].push_back({last, b});
   endtask

   // Packet-level reference: serve the next non-empty requester after the
   // previous grant; each grant is a header then bytes until last or MAXL.
   task automatic model_build();
      int unsigned r;
      int unsigned c;
      int unsigned cnt;
      bit          found;
      bit          done;
      logic [8:0]  it;
      forever begin
         found = 0;
         r = 0;
         for (int unsigned k = 1; k <= NREQ; k++) begin
            c = (model_last + k) % NREQ;
            if (!found && mq[c].size() > 0) begin
               r = c;
               found = 1;
            end
         end
         if (!found) break;
         exp_q.push_back({1'b0, 4'hA, 4'(r)});
         cnt = 0;
         done = 0;
         while (!done) begin
            it = mq[r].pop_front();
            cnt++;
            done = it[8] || (cnt == MAXL);
            exp_q.push_back({(cnt == MAXL) && !it[8], it[7:0]});
         end
         model_last = r;
      end
   endtask

   function automatic bit drv_pending();
      bit p = 0;
      for (int unsigned r = 0; r < NREQ; r++) if (drv_q[r].size() > 0) p = 1;
      return p;
   endfunction

   task automatic run_phase(input string name, input int unsigned budget);
      int unsigned cyc = 0;
      while ((exp_q.size() != 0 || drv_pending()) && cyc < budget) begin
         @(posedge clk);
         cyc++;
      end
      repeat (4) @(posedge clk);
      check({name, "_drained"}, exp_q.size(), 0);
      if (exp_q.size() != 0 || drv_pending()) begin
         exp_q.delete();
         for (int unsigned r = 0; r < NREQ; r++) drv_q[r].delete();
         drive_outputs();
      end
   endtask

   // Requester drivers and almost_full generator
   initial begin
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int unsigned r = 0; r < NREQ; r++)
            if (acc[r] && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
         drive_outputs();
         if (af_burst > 0) begin
            uart_almost_full = 1'b1;
            af_burst--;
         end else begin
            uart_almost_full = ($urandom_range(99) < af_pct);
         end
      end
   end

   // Monitor: compare every UART write and the err_overlen pulse timing
   initial begin : mon
      logic [8:0] item;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("err_overlen", err_overlen, err_exp);
            err_exp = 1'b0;
            if (uart_almost_full) begin
               check("af_uart_wr", uart_wr, 0);
               check("af_req_ready", req_ready, 0);
            end
            if (busy_cnt_en && busy) busy_cnt++;
            if (uart_wr) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL extra_write: got 0x%0h, expected no write at %0t", uart_din, $time);
               end else begin
                  item = exp_q.pop_front();
                  check("uart_din", uart_din, item[7:0]);
                  err_exp = item[8];
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned wcnt;
      int unsigned npk;
      int unsigned len;
      bit          hdr_seen;

      // Reset values
      #1;
      check("rst_uart_wr", uart_wr, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_overlen, 0);
      check("rst_grant_id", grant_id, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #2;

      // Single packet on req0, busy for header + 3 bytes
      busy_cnt = 0;
      busy_cnt_en = 1'b1;
      add_byte(0, 8'h11, 0);
      add_byte(0, 8'h22, 0);
      add_byte(0, 8'h33, 1);
      drive_outputs();
      model_build();
      run_phase("single", 200);
      busy_cnt_en = 1'b0;
      check("single_busy_cycles", busy_cnt, 4);

      // Fairness: req0 and req1 each offer two 2-byte packets
      #2;
      add_byte(0, 8'h01, 0); add_byte(0, 8'h02, 1);
      add_byte(0, 8'h03, 0); add_byte(0, 8'h04, 1);
      add_byte(1, 8'h05, 0); add_byte(1, 8'h06, 1);
      add_byte(1, 8'h07, 0); add_byte(1, 8'h08, 1);
      drive_outputs();
      model_build();
      run_phase("fair", 300);

      // Backpressure: 5-cycle almost_full burst mid-payload
      #2;
      add_byte(2, 8'h21, 0); add_byte(2, 8'h22, 0); add_byte(2, 8'h23, 1);
      add_byte(0, 8'h31, 0); add_byte(0, 8'h32, 1);
      drive_outputs();
      model_build();
      repeat (3) @(posedge clk);
      #2;
      af_burst = 5;
      run_phase("backpressure", 300);

      // Over-length: 6 bytes on req1 with MAXL=4
      #2;
      for (int unsigned i = 0; i < 6; i++) add_byte(1, 8'(8'h41 + i), i == 5);
      drive_outputs();
      model_build();
      run_phase("overlen", 300);

      // Exact limit: last on the 4th byte
      #2;
      for (int unsigned i = 0; i < 4; i++) add_byte(2, 8'(8'h51 + i), i == 3);
      drive_outputs();
      model_build();
      run_phase("exact", 300);

      // Randomized traffic with random backpressure
      af_pct = 30;
      for (int unsigned round = 0; round < 20; round++) begin
         #2;
         for (int unsigned r = 0; r < NREQ; r++) begin
            npk = $urandom_range(2);
            for (int unsigned p = 0; p < npk; p++) begin
               len = $urandom_range(7, 1);
               for (int unsigned b = 0; b < len; b++) add_byte(r, 8'($urandom), b == len - 1);
            end
         end
         drive_outputs();
         model_build();
         run_phase("random", 2000);
      end
      af_pct = 0;
      repeat (3) @(posedge clk);

      // Reset mid-DATA after the 2nd payload byte
      #2;
      mon_en = 1'b0;
      drv_q[0].push_back({1'b0, 8'h71});
      drv_q[0].push_back({1'b0, 8'h72});
      drv_q[0].push_back({1'b1, 8'h73});
      drive_outputs();
      wcnt = 0;
      for (int i = 0; i < 20 && wcnt < 3; i++) begin
         @(negedge clk);
         if (uart_wr) wcnt++;
      end
      check("rst_pre_writes", wcnt, 3);
      @(posedge clk);
      #2;
      drv_q[1].push_back({1'b0, 8'h81});
      drv_q[1].push_back({1'b1, 8'h82});
      rst_n = 1'b0;
      #1;
      check("midrst_uart_wr", uart_wr, 0);
      check("midrst_req_ready", req_ready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_grant_id", grant_id, 0);
      check("midrst_err", err_overlen, 0);
      drv_q[0].delete();
      drive_outputs();
      repeat (2) @(posedge clk);
      #2;
      model_last = NREQ - 1;
      mq[1].push_back({1'b0, 8'h81});
      mq[1].push_back({1'b1, 8'h82});
      model_build();
      err_exp = 1'b0;
      rst_n = 1'b1;
      mon_en = 1'b1;
      hdr_seen = 0;
      for (int i = 0; i < 2 && !hdr_seen; i++) begin
         @(negedge clk);
         if (uart_wr && uart_din == 8'hA1) hdr_seen = 1;
      end
      check("postrst_hdr_latency", hdr_seen, 1);
      run_phase("postrst", 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART transmit write port between up to 16 byte-stream requesters, such as the I2C response path, status/event reporter and debug echo. Each grant covers one whole packet, prefixed by a one-byte header that identifies the source. The block sits directly in front of the `uart` write interface (`wr`/`din`/`almost_full`) and never overruns the UART FIFO.

## Interface

- `NUM_REQ`, 2: number of requesters; range 2..16.
- `DATA_WIDTH`, 8: byte width; fixed at 8 (the header format depends on it).
- `HDR_TAG`, 4'hA: upper nibble of every header byte.
- `MAX_LEN`, 64: maximum payload bytes per grant; range 1..255.

- `clk` input 1: system clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: per-requester byte valid.
- `req_data` input NUM_REQ*8: requester i's byte is at [8i+7:8i].
- `req_last` input NUM_REQ: marks the final byte of a packet; qualified by valid.
- `req_ready` output NUM_REQ: per-requester byte accepted; a transfer occurs when valid && ready.
- `uart_wr` output 1: write strobe to the UART TX FIFO.
- `uart_din` output 8: byte written when `uart_wr` is high.
- `uart_almost_full` input 1: from the UART; no write is issued while it is high.
- `grant_id` output 4: index of the current or last granted requester.
- `busy` output 1: high in HDR or DATA.
- `err_overlen` output 1: one-cycle pulse when a grant is cut at MAX_LEN.

## Operation

- FSM states: IDLE, HDR, DATA. Registered state: `state`, `grant_id`, `last_ptr`, `byte_cnt` (8 bits).
- IDLE:
  - If any `req_valid` is high, select the first valid index scanning `last_ptr+1`, `last_ptr+2`, … modulo NUM_REQ.
  - Register that index into `grant_id` and go to HDR.
  - `req_ready` is all-zero.
- HDR:
  - `uart_din = {HDR_TAG, grant_id}`; `uart_wr = !uart_almost_full`.
  - Go to DATA on the cycle the write issues. Otherwise hold.
  - The header is sent even if the granted requester has dropped `req_valid`.
- DATA:
  - `req_ready[grant_id] = !uart_almost_full`; every other ready bit is 0.
  - `uart_wr = req_valid[grant_id] && !uart_almost_full`.
  - `uart_din = req_data[grant_id]`.
  - Each transfer increments `byte_cnt`.
- End of grant, on a DATA transfer with `req_last`, or with `byte_cnt == MAX_LEN-1`:
  - Set `last_ptr <= grant_id`, clear `byte_cnt`, return to IDLE.
  - If the grant ended on the count limit without `req_last`, pulse `err_overlen` in the next cycle. The rest of that packet continues under a fresh header on its next grant.
- If `req_last` and the limit coincide on the same transfer, this is a normal end and there is no error.
- Requesters must hold `req_data`/`req_last` stable while valid && !ready. The arbiter never drops or duplicates bytes.
- `uart_wr` and `req_ready` are combinational from registered state and `uart_almost_full`. `uart_din` is a combinational mux.
- Requesters that are not granted are never starved: at most NUM_REQ-1 packets are served ahead of any waiting requester.

## Timing

- Reset values:
  - state IDLE, `grant_id` 0, `last_ptr` NUM_REQ-1 (so requester 0 wins first), `byte_cnt` 0.
  - `busy`, `err_overlen`, `uart_wr`, `req_ready` all 0.
- Latency: with `req_valid` high at cycle N in IDLE, the header is written at N+1 if not almost full. The first payload byte can be written at N+2.
- Throughput: one byte per cycle in DATA. One idle cycle plus one header cycle separate consecutive packets.
- `uart_almost_full` high stalls HDR or DATA with no state change. Writes resume in the same cycle it falls.
- Simultaneous requests in IDLE are resolved by the round-robin order. A request that rises during DATA waits for the end of the grant.
- When `rst_n` asserts mid-packet, everything clears immediately (asynchronously). A partially sent packet is not completed, and `uart_wr` drops in the same cycle.
- `rst_n` deassertion is synchronised externally. The first grant can occur on the first edge after release.

## Test plan

- Single packet: req0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33) -> UART receives 0xA0, 0x11, 0x22, 0x33. `busy` is high for 4 cycles, then IDLE.
- Fairness: req0 and req1 continuously offer 2-byte packets -> headers alternate 0xA0, 0xA1, 0xA0, 0xA1. After reset the first grant goes to req0.
- Backpressure: raise `almost_full` for 5 cycles mid-payload -> `uart_wr`=0 and `req_ready`=0 throughout, with no loss or duplication. The byte order is identical to the unstalled run.
- Over-length: MAX_LEN=4, req1 sends 6 bytes with last on byte 6 -> output is 0xA1 plus 4 bytes, an `err_overlen` pulse, then 0xA1 plus 2 bytes.
- Exact limit: MAX_LEN=4, with `req_last` on the 4th byte -> no `err_overlen`.
- Reset mid-DATA: assert `rst_n`=0 after the 2nd payload byte -> `uart_wr` is 0 at once and outputs take their reset values. After release, a pending req1 gets header 0xA1 within 2 cycles.
